// File: rtl/avalon_arbiter.sv
// avalon_arbiter: two-master Avalon-MM arbiter in front of a single RAM slave.
// Master 0 is the instruction-fetch port, master 1 the load/store port.
// Whole transactions are granted round-robin; the losing master is held off
// with waitrequest.
//
// Optional build macro ARB_TIMEOUT_EN: adds a 16-bit stall counter that
// aborts a slave transfer stuck in waitrequest for TIMEOUT_CYCLES cycles,
// returns ERROR_READDATA to the owner and raises the sticky bus_error flag.
// Without the macro, stalls wait indefinitely and bus_error is tied low.
//
// Handshake: a master presents a command with read|write high and holds it
// (address, data, byteenable stable) until it samples waitrequest low at a
// rising edge; that edge completes the transfer. Read and write high together
// is treated as a write.
module avalon_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERROR_READDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic        bus_error
);

  // State encoding is one-hot on the owner, so the state register doubles as
  // the grant output and as the externally visible FSM state.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant;
  logic       last_grant_next;
  logic       req0;
  logic       req1;
  logic       req_cur;
  logic       done;
  logic       abort;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign grant = state;

  // Request line of whichever master currently owns the slave.
  always_comb begin
    req_cur = 1'b0;
    case (state)
      GRANT0:  req_cur = req0;
      GRANT1:  req_cur = req1;
      default: req_cur = 1'b0;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt;
  logic        err_q;

  // The abort cycle is the TIMEOUT_CYCLES-th stalled cycle of one grant.
  assign abort = req_cur & s_waitrequest & (stall_cnt == STALL_LAST);

  // Count stalled grant cycles; restart whenever the owner changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (state_next != state) begin
      stall_cnt <= '0;
    end else if ((state != IDLE) && s_waitrequest) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign bus_error = err_q;
`else
  assign abort     = 1'b0;
  assign bus_error = 1'b0;
`endif

  // A transfer ends on a real slave acknowledge or on a forced abort.
  assign done = req_cur & (~s_waitrequest | abort);

  // Round-robin arbitration and transaction-level ownership.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant)) begin
          state_next      = GRANT0;
          last_grant_next = 1'b0;
        end else if (req1) begin
          state_next      = GRANT1;
          last_grant_next = 1'b1;
        end
      end
      GRANT0: begin
        if (!req0) begin
          state_next = IDLE;
        end else if (done) begin
          if (req1) begin
            state_next      = GRANT1;
            last_grant_next = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GRANT1: begin
        if (!req1) begin
          state_next = IDLE;
        end else if (done) begin
          if (req0) begin
            state_next      = GRANT0;
            last_grant_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and fairness pointer; last_grant resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Route the owner's command to the slave and the slave's response back.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
    case (state)
      GRANT0: begin
        s_address      = m0_address;
        s_read         = m0_read & ~m0_write & ~abort;
        s_write        = m0_write & ~abort;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest & ~abort;
        if (abort) m0_readdata = ERROR_READDATA;
      end
      GRANT1: begin
        s_address      = m1_address;
        s_read         = m1_read & ~m1_write & ~abort;
        s_write        = m1_write & ~abort;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest & ~abort;
        if (abort) m1_readdata = ERROR_READDATA;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/avalon_arbiter.md
# avalon_arbiter

Two-master Avalon memory-mapped arbiter sharing the single RAM slave between the CPU's instruction-fetch port (master 0) and data load/store port (master 1). Sits between top_level_CPU's bus-controller outputs and the RAM. Grants whole transactions round-robin, stalls the losing master with waitrequest, and with the timeout feature compiled in, aborts hung slave transfers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: slave-stall cycles before forced abort. Range 1..65535.
- ERROR_READDATA, 32'hDEADBEEF: readdata returned on an aborted read.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  32  master byte address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  32  write data
- m0_byteenable / m1_byteenable  in  4  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  stall to master
- m0_readdata / m1_readdata  out  32  read data to master
- s_address  out  32;  s_read  out  1;  s_write  out  1;  s_writedata  out  32;  s_byteenable  out  4  slave command
- s_waitrequest  in  1;  s_readdata  in  32  slave response
- grant  out  2  one-hot current owner; 2'b00 when idle
- bus_error  out  1  sticky timeout flag

## Operation
- A master requests when read|write is high. Read and write both high is illegal; treated as a write.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE: slave command outputs all zero; both m*_waitrequest = 1. Arbitration: only one requesting → grant it; both → grant the master not in last_grant. Next state GRANT0/GRANT1; last_grant updated on entry.
- GRANTx: s_* driven combinationally from master x; mx_waitrequest = s_waitrequest; the other master sees waitrequest = 1. Both m*_readdata = s_readdata (except on abort).
- Completion: cycle in GRANTx with master x requesting and s_waitrequest = 0. Next state: GRANT of the other master if it is requesting, otherwise IDLE. A master never retains the bus across consecutive transactions when the other is waiting.
- Granted master drops request without completion (protocol violation): → IDLE next cycle, no error flagged.
- Reset assertion at any time: state IDLE, stall counter 0, last_grant = 1 (master 0 wins the first tie), bus_error = 0. Any in-flight slave transfer is abandoned.

## Timing
- Reset values: grant 2'b00, s_read/s_write 0, s_address/s_writedata 0, s_byteenable 0, m0/m1_waitrequest 1, m*_readdata = s_readdata, bus_error 0.
- Arbitration latency: request first seen in IDLE in cycle N → slave sees command in cycle N+1. Minimum transaction occupancy: 1 cycle in GRANT.
- Back-to-back handoff: completion in cycle N with other master waiting → other master's command on slave in cycle N+1, no bubble.
- Same master re-requesting with no contention: one IDLE bubble between transactions.
- grant is registered state; changes only on clk rising edge or reset.

## Configuration
- ARB_TIMEOUT_EN defined: 16-bit stall counter increments each GRANT cycle with s_waitrequest = 1 and clears on state change. When it reaches TIMEOUT_CYCLES, that cycle is an abort: s_read/s_write forced 0, mx_waitrequest = 0, mx_readdata = ERROR_READDATA, bus_error set (sticky until reset); FSM proceeds as on normal completion.
- ARB_TIMEOUT_EN undefined: no counter, stalls wait indefinitely, bus_error tied 0, ERROR_READDATA unused.

## Test plan
- Reset low mid-transfer in GRANT1 → grant = 00, s_read = 0, both waitrequests = 1 on the same cycle; after release, simultaneous requests grant master 0 first.
- Master 0 reads 0x04 alone, RAM returns 0x24020010 after 2 wait cycles → grant = 01 one cycle after request; m0_readdata = 0x24020010 on completion; grant = 00 next cycle.
- Both masters request continuously (m0 read 0x08, m1 write 0x70 to 0x100, byteenable 4'hF) → grants alternate 01,10,01,… with no IDLE cycles; RAM location 0x100 = 0x70.
- Master 1 holds request while master 0 issues 5 consecutive fetches → master 1 granted after at most one master-0 transaction.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave holds waitrequest high → abort on 8th stall cycle, m0_readdata = 0xDEADBEEF, m0_waitrequest = 0, bus_error = 1 and stays 1.
- Granted master drops read before s_waitrequest falls → IDLE next cycle, bus_error stays 0.
